// File: rtl/vga_timing_pkg.sv
// 640x480 @ 60 Hz VGA timing constants shared by the sync generator.
// Counter width is fixed at 10 bits, so both totals must fit in 1024.
package vga_timing_pkg;

  localparam int CNT_W = 10;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam int VGA_DIV    = 4;
  localparam int VGA_H_VIS  = 640;
  localparam int VGA_H_FP   = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP   = 48;
  localparam int VGA_V_VIS  = 480;
  localparam int VGA_V_FP   = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP   = 33;

  localparam int VGA_H_TOT = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOT = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int VGA_HS_START = VGA_H_VIS + VGA_H_FP;
  localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC - 1;
  localparam int VGA_VS_START = VGA_V_VIS + VGA_V_FP;
  localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC - 1;

  function automatic logic in_range(input cnt_t val, input cnt_t lo, input cnt_t hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Pixel-rate enable: modulo-DIV counter, p_tick decoded from the counter register.
module pixel_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  localparam int            W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0]  LAST = W'(DIV - 1);

  logic [W-1:0] div_cnt;

  generate
    if (DIV < 2) begin : g_div_chk
      $error("pixel_tick_gen: DIV must be at least 2");
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (div_cnt == LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + W'(1);
    end
  end

  assign p_tick = (div_cnt == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel/line counters plus registered sync, blanking and frame flags.
// Flags are loaded from the next-state counters so they switch on the same edge as pixel_x/pixel_y.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int DIV    = VGA_DIV,
  parameter int H_VIS  = VGA_H_VIS,
  parameter int H_FP   = VGA_H_FP,
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_BP   = VGA_H_BP,
  parameter int V_VIS  = VGA_V_VIS,
  parameter int V_FP   = VGA_V_FP,
  parameter int V_SYNC = VGA_V_SYNC,
  parameter int V_BP   = VGA_V_BP
) (
  input  logic             clk,
  input  logic             reset,
  output logic             p_tick,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             frame_start
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam cnt_t H_LAST  = cnt_t'(H_TOT - 1);
  localparam cnt_t V_LAST  = cnt_t'(V_TOT - 1);
  localparam cnt_t H_VIS_C = cnt_t'(H_VIS);
  localparam cnt_t V_VIS_C = cnt_t'(V_VIS);
  localparam cnt_t HS_LO   = cnt_t'(H_VIS + H_FP);
  localparam cnt_t HS_HI   = cnt_t'(H_VIS + H_FP + H_SYNC - 1);
  localparam cnt_t VS_LO   = cnt_t'(V_VIS + V_FP);
  localparam cnt_t VS_HI   = cnt_t'(V_VIS + V_FP + V_SYNC - 1);

  generate
    if (H_TOT > 1024 || V_TOT > 1024) begin : g_range_chk
      $error("vga_sync_gen: H_TOT/V_TOT exceed the 10-bit counter range");
    end
  endgenerate

  cnt_t h_next;
  cnt_t v_next;
  logic h_wrap;

  pixel_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .p_tick (p_tick)
  );

  always_comb begin
    h_wrap = (pixel_x == H_LAST);
    h_next = h_wrap ? '0 : pixel_x + cnt_t'(1);
    v_next = pixel_y;
    if (h_wrap) begin
      v_next = (pixel_y == V_LAST) ? '0 : pixel_y + cnt_t'(1);
    end
  end

  // Reset parks the raster on the last blanking pixel so the first tick lands on (0, 0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel_x     <= H_LAST;
      pixel_y     <= V_LAST;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      frame_start <= 1'b0;
    end else if (p_tick) begin
      pixel_x     <= h_next;
      pixel_y     <= v_next;
      hsync       <= !in_range(h_next, HS_LO, HS_HI);
      vsync       <= !in_range(v_next, VS_LO, VS_HI);
      video_on    <= (h_next < H_VIS_C) && (v_next < V_VIS_C);
      frame_start <= (h_next == '0) && (v_next == '0);
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: full horizontal timing, shortened vertical timing to keep frames short.
module tb_vga_sync_gen;

  localparam int DIV    = 4;
  localparam int H_VIS  = 640, H_FP = 16, H_SYNC = 96, H_BP = 48;
  localparam int V_VIS  = 4,   V_FP = 1,  V_SYNC = 2,  V_BP = 1;
  localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FRAME_PIX = H_TOT * V_TOT;
  localparam int LINE_CLK  = H_TOT * DIV;
  localparam int FRAME_CLK = FRAME_PIX * DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       p_tick;
  logic [9:0] pixel_x, pixel_y;
  logic       hsync, vsync, video_on, frame_start;

  int tests = 0;
  int fails = 0;
  int clk_since_rel = 0;

  vga_sync_gen #(
    .DIV(DIV), .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .hsync(hsync), .vsync(vsync), .video_on(video_on), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: the raster position is simply elapsed clocks / DIV, offset by one so
  // that the pre-first-tick state is the last pixel of the frame.
  task automatic model_check(input int c);
    int   p, x, y;
    logic e_tick, e_hs, e_vs, e_von, e_fs;
    p      = (c / DIV + FRAME_PIX - 1) % FRAME_PIX;
    x      = p % H_TOT;
    y      = p / H_TOT;
    e_tick = (c % DIV) == DIV - 1;
    e_hs   = !(x >= 656 && x <= 751);
    e_vs   = !(y >= V_VIS + V_FP && y <= V_VIS + V_FP + V_SYNC - 1);
    e_von  = (x < H_VIS) && (y < V_VIS);
    e_fs   = (x == 0) && (y == 0) && (c >= DIV);
    tests++;
    if (p_tick !== e_tick || pixel_x !== 10'(x) || pixel_y !== 10'(y) || hsync !== e_hs ||
        vsync !== e_vs || video_on !== e_von || frame_start !== e_fs) begin
      fails++;
      $display("FAIL cycle %0d: got tick=%b x=%0d y=%0d hs=%b vs=%b von=%b fs=%b, expected tick=%b x=%0d y=%0d hs=%b vs=%b von=%b fs=%b",
               c, p_tick, pixel_x, pixel_y, hsync, vsync, video_on, frame_start,
               e_tick, x, y, e_hs, e_vs, e_von, e_fs);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (reset) clk_since_rel = 0;
    else       clk_since_rel++;
    model_check(clk_since_rel);
  end

  task automatic reset_hold_release(input string tag);
    repeat (5) @(negedge clk);
    check({tag, "_rst_x"}, pixel_x, 799);
    check({tag, "_rst_y"}, pixel_y, V_TOT - 1);
    check({tag, "_rst_sync"}, {hsync, vsync, video_on, frame_start, p_tick}, 5'b11000);
    reset = 1'b0;
  endtask

  task automatic first_pixel_seq(input string tag);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      check({tag, "_tick"}, p_tick, (k == 3));
      if (k < 4) check({tag, "_hold_x"}, pixel_x, 799);
    end
    check({tag, "_first_xy"}, {pixel_x, pixel_y}, 20'd0);
    check({tag, "_first_flags"}, {video_on, frame_start, hsync, vsync}, 4'b1111);
  endtask

  initial begin
    #900000;
    $display("FAIL timeout: simulation did not complete, got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int von_cnt = 0, tick_cnt = 0, vs_low = 0, fs_cnt = 0;
    int hs_fall_x = -1, hs_rise_x = -1, line_len = -1, fs_first = -1, fs_second = -1;
    int max_x = 0, max_y = 0, wrap_vis = -1, wrap_frame = -1;
    logic [9:0] prev_x, prev_y;
    logic prev_hs, prev_fs;
    bit found;

    reset_hold_release("init");
    first_pixel_seq("init");

    prev_x = 10'd799; prev_y = 10'(V_TOT - 1); prev_hs = 1'b1; prev_fs = 1'b0;
    for (int i = 0; i < 2 * FRAME_CLK; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (i < LINE_CLK) begin
        von_cnt  += int'(video_on);
        tick_cnt += int'(p_tick);
        if (prev_hs && !hsync && hs_fall_x < 0) hs_fall_x = int'(pixel_x);
        if (!prev_hs && hsync && hs_rise_x < 0) hs_rise_x = int'(pixel_x);
      end
      if (i > 0 && line_len < 0 && prev_x != 0 && pixel_x == 0) line_len = i;
      if (i < FRAME_CLK) vs_low += int'(!vsync);
      if (!prev_fs && frame_start) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = i;
        else if (fs_second < 0) fs_second = i;
      end
      if (int'(pixel_x) > max_x) max_x = int'(pixel_x);
      if (int'(pixel_y) > max_y) max_y = int'(pixel_y);
      if (prev_x == 799 && prev_y == 10'(V_VIS - 1) && pixel_x != prev_x && wrap_vis < 0)
        wrap_vis = int'({pixel_x, pixel_y, video_on});
      if (prev_x == 799 && prev_y == 10'(V_TOT - 1) && pixel_x != prev_x && wrap_frame < 0)
        wrap_frame = int'({pixel_x, pixel_y, video_on});
      prev_x = pixel_x; prev_y = pixel_y; prev_hs = hsync; prev_fs = frame_start;
    end

    check("line_ticks", tick_cnt, 800);
    check("line_video_on_clks", von_cnt, 640 * DIV);
    check("hsync_fall_x", hs_fall_x, 656);
    check("hsync_rise_x", hs_rise_x, 752);
    check("line_len_clks", line_len, 3200);
    check("vsync_low_clks", vs_low, 2 * H_TOT * DIV);
    check("frame_start_count", fs_cnt, 2);
    check("frame_start_first", fs_first, 0);
    check("frame_start_period", fs_second - fs_first, FRAME_CLK);
    check("max_x", max_x, 799);
    check("max_y", max_y, V_TOT - 1);
    check("wrap_to_blank", wrap_vis, {10'd0, 10'd4, 1'b0});
    check("wrap_to_origin", wrap_frame, {10'd0, 10'd0, 1'b1});

    found = 1'b0;
    for (int i = 0; i < 30000 && !found; i++) begin
      @(posedge clk); #1;
      if (pixel_x == 10'd700 && pixel_y == 10'(V_VIS + V_FP + V_SYNC - 1)) found = 1'b1;
    end
    check("reach_mid_sync", found, 1);
    check("mid_sync_low", {hsync, vsync}, 2'b00);
    #1 reset = 1'b1;
    #1;
    check("async_rst_sync", {hsync, vsync, video_on, frame_start, p_tick}, 5'b11000);
    check("async_rst_xy", {pixel_x, pixel_y}, {10'd799, 10'(V_TOT - 1)});

    reset_hold_release("again");
    first_pixel_seq("again");
    repeat (40) @(posedge clk);
    #2;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

- Generates 640x480 @ 60 Hz VGA timing from the 100 MHz system clock.
- Produces a pixel-rate enable (`p_tick`), horizontal/vertical counters (`pixel_x`, `pixel_y`), active-low `hsync`/`vsync`, and `video_on`.
- Sits directly upstream of the RGB output multiplexer: `video_on` gates the pixel colour there, and `pixel_x`/`pixel_y` drive the pixel/text generators that produce `color`.

## Interface
- `DIV`, 4: system clocks per pixel; `p_tick` period. Must be ≥ 2.
- `H_VIS`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch.
- `H_SYNC`, 96: hsync pulse width.
- `H_BP`, 48: horizontal back porch.
- `V_VIS`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch.
- `V_SYNC`, 2: vsync pulse width.
- `V_BP`, 33: vertical back porch.

Ports:
- `clk` in 1: system clock, 100 MHz.
- `reset` in 1: asynchronous, active-high.
- `p_tick` out 1: one-`clk` pulse every `DIV` clocks.
- `pixel_x` out 10: horizontal count, 0..H_TOT-1 (H_TOT = 800).
- `pixel_y` out 10: vertical count, 0..V_TOT-1 (V_TOT = 525).
- `hsync` out 1: active-low horizontal sync.
- `vsync` out 1: active-low vertical sync.
- `video_on` out 1: high when `pixel_x < H_VIS` and `pixel_y < V_VIS`.
- `frame_start` out 1: high while (`pixel_x`, `pixel_y`) = (0, 0).

## Operation
- Divider: `div_cnt` counts 0..DIV-1 on every `clk`, wrapping to 0. `p_tick` = (`div_cnt` == DIV-1), decoded from the register.
- Counters: advance only on a `clk` edge where `p_tick` = 1.
  - `h` increments; at H_TOT-1 it wraps to 0 and `v` increments.
  - `v` wraps from V_TOT-1 to 0 only when `h` also wraps.
  - No other state; no FSM beyond the two modulo counters.
- `hsync` = 0 iff `pixel_x` ∈ [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1] = [656, 751].
- `vsync` = 0 iff `pixel_y` ∈ [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1] = [490, 491].
- `hsync`, `vsync`, `video_on` and `frame_start` are registers loaded from the next-state counter values. They change on the same edge as `pixel_x`/`pixel_y` and are always consistent with them (zero skew, glitch-free).
- Arithmetic: unsigned, 10-bit. Elaboration fails if H_TOT > 1024 or V_TOT > 1024.
- Reset state (async, immediate), chosen so the first pixel after reset is (0, 0):
  - `div_cnt` = 0, `p_tick` = 0.
  - `pixel_x` = 799, `pixel_y` = 524.
  - `hsync` = 1, `vsync` = 1, `video_on` = 0, `frame_start` = 0.
  - This state is self-consistent: (799, 524) lies in blanking, outside both sync windows.
- Reset asserted mid-frame or mid-sync pulse: all outputs return to the reset values at once. No partial pulse is resumed. The sequence restarts identically after release.

## Timing
- After `reset` falls, `p_tick` is first high in the cycle where `div_cnt` = DIV-1 (4th `clk` for DIV = 4).
- On that edge the outputs become (0, 0) with `video_on` = 1 and `frame_start` = 1.
- Each output value holds for exactly DIV `clk` cycles.
- Line: 800 × DIV = 3200 clocks. Frame: 525 lines = 1,680,000 clocks (59.52 Hz).
- `hsync` low for 96 pixel periods, starting at the pixel-655→656 transition.
- `vsync` low for 2 full lines, starting at the edge where (799, 489) → (0, 490).
- Downstream stages register colour using `p_tick`. RGB output is one pixel later than `pixel_x`; consumers delaying colour by one pixel also delay `hsync`/`vsync`/`video_on` by one pixel. That delay is outside this block.

## Structure
- Package `vga_timing_pkg`:
  - localparams for the 640x480 timing set.
  - H_TOT and V_TOT.
  - Derived sync start/end constants.
  - Counter width (10).
- Sub-module `pixel_tick_gen`: the `DIV` modulo counter and `p_tick` decode; parameter `DIV`.
- Counters, sync decode and output registers stay in `vga_sync_gen`.

## Test plan
- Reset release: hold `reset` 5 clocks, then release. During reset, outputs are (799, 524, hsync 1, vsync 1, video_on 0). `p_tick` is first high at clock 4. On that edge the outputs become (0, 0, video_on 1, frame_start 1).
- Line timing: measure one line. `p_tick` count = 800. `video_on` high for 640 pixels. `hsync` falls entering x = 656 and rises entering x = 752. Line length = 3200 clocks.
- Frame timing: run 2 full frames. `vsync` low exactly while y ∈ {490, 491} (1600 pixels). `frame_start` pulses once per frame, 1,680,000 clocks apart.
- Wrap-around: at (799, 479) the next pixel is (0, 480) with `video_on` 0. At (799, 524) the next pixel is (0, 0) with `video_on` 1. `pixel_x` never exceeds 799 and `pixel_y` never exceeds 524.
- Mid-sync reset: assert `reset` at (700, 491), with `hsync` and `vsync` both low. Both go high asynchronously, before the next `clk` edge. After release, the first-pixel sequence repeats exactly as in the reset-release scenario.
- Consistency checker (continuous): every `clk` cycle, `video_on`, `hsync`, `vsync` and `frame_start` equal the decode of the current `pixel_x`/`pixel_y`. Counters change only on `p_tick` edges.
